cordic_job_scheduler: RTL and testbench
=======================================

Name: cordic_job_scheduler

Overview:
- Shares one iterative CORDIC core between two requesters, A and B, using round-robin arbitration.
- Accepts an 8-bit angle job from a requester, then loads the core's z input and fires its single-cycle start strobe.
- Waits for the core's done strobe, or for a timeout, and returns cos/sin (core x/y outputs) tagged with the requester ID.
- Sits between the top-level I/O glue and the CORDIC core; the core's x_i/y_i stay tied to constants outside this block.

Parameters:
- DATA_WIDTH, 8, width of angle and result words.
- TIMEOUT_CYCLES, 32, cycles in WAIT without done before the job is aborted; must be >= 2.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset
- req_a_valid_i  input  1  requester A has a job
- req_a_angle_i  input  DATA_WIDTH  requester A angle
- req_a_ready_o  output  1  A's job is accepted this cycle (when valid & ready)
- req_b_valid_i  input  1  requester B has a job
- req_b_angle_i  input  DATA_WIDTH  requester B angle
- req_b_ready_o  output  1  B's job is accepted this cycle
- cordic_z_o  output  DATA_WIDTH  angle driven to the core
- cordic_start_o  output  1  one-cycle start strobe to the core
- cordic_x_i  input  DATA_WIDTH  core x result (cos)
- cordic_y_i  input  DATA_WIDTH  core y result (sin)
- cordic_done_i  input  1  core result-valid strobe
- res_valid_o  output  1  result available
- res_ready_i  input  1  consumer takes the result
- res_id_o  output  1  0 = A, 1 = B
- res_cos_o  output  DATA_WIDTH  latched x
- res_sin_o  output  DATA_WIDTH  latched y
- res_err_o  output  1  result is a timeout abort
- busy_o  output  1  state != IDLE

Behaviour:
- Clocking and reset: one clock, clk_i; reset rst_i is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, last_served = B so A wins the first tie. Reset mid-job abandons the job and produces no result.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, grant:
  - Both valid: grant goes to the requester not equal to last_served.
  - One valid: grant goes to that requester.
  - req_x_ready_o = (state==IDLE) & grant_x. Ready is combinational and at most one is high.
  - On handshake: latch angle into the z register, latch the ID, go to ISSUE.
  - Neither valid: stay in IDLE.
- ISSUE: cordic_start_o=1 for exactly this cycle; cordic_z_o = latched angle; clear the timeout counter; go to WAIT.
- WAIT:
  - cordic_z_o is held stable. The counter increments each cycle.
  - cordic_done_i=1: latch cordic_x_i/cordic_y_i into res_cos/res_sin, res_err=0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 without done: res_cos=res_sin=0, res_err=1, go to RESP.
  - Done and timeout on the same cycle: done wins, err=0.
- RESP:
  - res_valid_o=1 with all res_* fields stable until res_ready_i=1.
  - On that cycle: last_served = res_id, then go to IDLE.
  - No new request is accepted while in RESP.
  - res_ready_i may be held high permanently, giving single-cycle RESP.
- Latency: handshake in cycle N → start in cycle N+1 → WAIT from N+2. Done seen in cycle M → res_valid_o from M+1.
- cordic_done_i outside WAIT (IDLE/ISSUE/RESP) is ignored; no state or output change.
- Requester angle changes after the handshake have no effect; only the latched value is used.
- Result widths are passed through unchanged; no arithmetic beyond the counter. Counter width = clog2(TIMEOUT_CYCLES).
- Back-to-back throughput: RESP → IDLE takes one cycle, and the next handshake can occur in that IDLE cycle.

Decomposition:
- Shared package cordic_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - requester ID constants REQ_A=0, REQ_B=1;
  - DATA_WIDTH default.
- One natural sub-module: rr_arbiter2, a two-input round-robin grant with last_served input.
- The FSM, latches and timeout counter stay in the top module.

Test Plan:
- Reset, then A valid with angle 0x20; core returns done with x=0x40, y=0x30 on the 4th WAIT cycle.
  - Required: start pulses once with z=0x20; res_valid, id=0, cos=0x40, sin=0x30, err=0.
- A and B both valid continuously (0x10 / 0x50), res_ready=1.
  - Required: service order A, B, A, B; each start shows the matching angle.
- Core never asserts done, TIMEOUT_CYCLES=32.
  - Required: res_valid exactly 32 cycles after WAIT entry, err=1, cos=sin=0.
- Done arrives on the same cycle as the timeout.
  - Required: err=0 and latched x/y are returned.
- res_ready held low for 10 cycles.
  - Required: res_valid and fields stable; both req ready low; a stray done pulse changes nothing.
- Assert rst_i low during WAIT.
  - Required: outputs immediately 0, state IDLE, no result.
  - After release, with both valid: A is granted first.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC job scheduler.
//   state_e            : scheduler FSM states
//   REQ_A / REQ_B      : requester ID encoding used on res_id_o and last-served
//   DATA_WIDTH_DEFAULT : default angle/result word width
package cordic_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant.
//   valid_a_i / valid_b_i : requests
//   last_served_i         : ID of the requester served most recently
//   grant_a_o / grant_b_o : one-hot (or zero) grant
// On a tie the requester that was not served last wins.
module rr_arbiter2
    import cordic_pkg::*;
(
    input  logic valid_a_i,
    input  logic valid_b_i,
    input  logic last_served_i,
    output logic grant_a_o,
    output logic grant_b_o
);

    assign grant_a_o = valid_a_i & (~valid_b_i | (last_served_i == REQ_B));
    assign grant_b_o = valid_b_i & (~valid_a_i | (last_served_i == REQ_A));

endmodule

// File: rtl/cordic_job_scheduler.sv
// Shares one iterative CORDIC core between requesters A and B.
//   req_a_* / req_b_* : valid/ready angle job inputs (ready is combinational)
//   cordic_*          : z angle + start strobe out, x/y results + done strobe in
//   res_*             : result channel (valid/ready), tagged with requester ID,
//                       res_err_o marks a timeout abort (cos/sin forced to 0)
//   busy_o            : scheduler not idle
module cordic_job_scheduler
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_a_valid_i,
    input  logic [DATA_WIDTH-1:0] req_a_angle_i,
    output logic                  req_a_ready_o,
    input  logic                  req_b_valid_i,
    input  logic [DATA_WIDTH-1:0] req_b_angle_i,
    output logic                  req_b_ready_o,
    output logic [DATA_WIDTH-1:0] cordic_z_o,
    output logic                  cordic_start_o,
    input  logic [DATA_WIDTH-1:0] cordic_x_i,
    input  logic [DATA_WIDTH-1:0] cordic_y_i,
    input  logic                  cordic_done_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic                  res_id_o,
    output logic [DATA_WIDTH-1:0] res_cos_o,
    output logic [DATA_WIDTH-1:0] res_sin_o,
    output logic                  res_err_o,
    output logic                  busy_o
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] z_q, z_d;
    logic                  id_q, id_d;
    logic                  last_q, last_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] cos_q, cos_d;
    logic [DATA_WIDTH-1:0] sin_q, sin_d;
    logic                  err_q, err_d;

    logic grant_a, grant_b;

    rr_arbiter2 u_arb (
        .valid_a_i     (req_a_valid_i),
        .valid_b_i     (req_b_valid_i),
        .last_served_i (last_q),
        .grant_a_o     (grant_a),
        .grant_b_o     (grant_b)
    );

    // Ready is masked by reset so no handshake is advertised while held in reset.
    assign req_a_ready_o  = rst_i & (state_q == ST_IDLE) & grant_a;
    assign req_b_ready_o  = rst_i & (state_q == ST_IDLE) & grant_b;
    assign cordic_start_o = (state_q == ST_ISSUE);
    assign cordic_z_o     = z_q;
    assign res_valid_o    = (state_q == ST_RESP);
    assign res_id_o       = id_q;
    assign res_cos_o      = cos_q;
    assign res_sin_o      = sin_q;
    assign res_err_o      = err_q;
    assign busy_o         = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        z_d     = z_q;
        id_d    = id_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_a_ready_o || req_b_ready_o) begin
                    z_d     = req_b_ready_o ? req_b_angle_i : req_a_angle_i;
                    id_d    = req_b_ready_o ? REQ_B : REQ_A;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // done takes priority over a coincident timeout
                if (cordic_done_i) begin
                    cos_d   = cordic_x_i;
                    sin_d   = cordic_y_i;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cos_d   = '0;
                    sin_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (res_ready_i) begin
                    last_d  = id_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            z_q     <= '0;
            id_q    <= REQ_A;
            last_q  <= REQ_B;   // A wins the first tie
            cnt_q   <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            id_q    <= id_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_cordic_job_scheduler.sv
// Self-checking bench for cordic_job_scheduler: job-level reference model with
// a per-cycle compare, plus directed scenarios with literal expectations.
module tb_cordic_job_scheduler;

    localparam int DW = 8;
    localparam int TO = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          va = 1'b0, vb = 1'b0;
    logic [DW-1:0] aa = '0, ab = '0;
    logic          ra, rb;
    logic [DW-1:0] cz;
    logic          cstart;
    logic [DW-1:0] cx = '0, cy = '0;
    logic          cdone = 1'b0;
    logic          rvalid;
    logic          rready = 1'b1;
    logic          rid;
    logic [DW-1:0] rcos, rsin;
    logic          rerr;
    logic          busy;

    always #5 clk = ~clk;

    cordic_job_scheduler #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .req_a_valid_i(va), .req_a_angle_i(aa), .req_a_ready_o(ra),
        .req_b_valid_i(vb), .req_b_angle_i(ab), .req_b_ready_o(rb),
        .cordic_z_o(cz), .cordic_start_o(cstart),
        .cordic_x_i(cx), .cordic_y_i(cy), .cordic_done_i(cdone),
        .res_valid_o(rvalid), .res_ready_i(rready), .res_id_o(rid),
        .res_cos_o(rcos), .res_sin_o(rsin), .res_err_o(rerr), .busy_o(busy)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- reference model (job lifecycle) ----------------
    // phase: 0 no job, 1 job accepted (start due), 2 core running, 3 result held
    int            m_phase;
    int            m_waited;
    logic          m_id, m_last, m_err;
    logic [DW-1:0] m_z, m_cos, m_sin;

    function automatic logic pick_a(input logic a, input logic b, input logic last);
        return a && (!b || last);
    endfunction
    function automatic logic pick_b(input logic a, input logic b, input logic last);
        return b && (!a || !last);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_waited <= 0; m_id <= 1'b0; m_last <= 1'b1;
            m_err <= 1'b0; m_z <= '0; m_cos <= '0; m_sin <= '0;
        end else begin
            case (m_phase)
                0: if (pick_a(va, vb, m_last)) begin
                       m_z <= aa; m_id <= 1'b0; m_phase <= 1;
                   end else if (pick_b(va, vb, m_last)) begin
                       m_z <= ab; m_id <= 1'b1; m_phase <= 1;
                   end
                1: begin m_phase <= 2; m_waited <= 0; end
                2: if (cdone) begin
                       m_cos <= cx; m_sin <= cy; m_err <= 1'b0; m_phase <= 3;
                   end else if (m_waited == TO - 1) begin
                       m_cos <= '0; m_sin <= '0; m_err <= 1'b1; m_phase <= 3;
                   end else begin
                       m_waited <= m_waited + 1;
                   end
                default: if (rready) begin m_last <= m_id; m_phase <= 0; end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("cmp_ready_a", ra, rst_n && m_phase == 0 && pick_a(va, vb, m_last));
        chk("cmp_ready_b", rb, rst_n && m_phase == 0 && pick_b(va, vb, m_last));
        chk("cmp_start", cstart, m_phase == 1);
        chk("cmp_z", cz, m_z);
        chk("cmp_busy", busy, m_phase != 0);
        chk("cmp_res_valid", rvalid, m_phase == 3);
        if (m_phase == 3) begin
            chk("cmp_res_id", rid, m_id);
            chk("cmp_res_cos", rcos, m_cos);
            chk("cmp_res_sin", rsin, m_sin);
            chk("cmp_res_err", rerr, m_err);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output logic [DW-1:0] z);
        bit ok = 0;
        z = '0;
        for (int i = 0; i < 100; i++) begin
            if (cstart) begin z = cz; ok = 1; break; end
            tick();
        end
        chk("start_seen", ok, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] z;
        logic [DW-1:0] zs [4];
        logic          ids [4];
        int            n;

        // reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_start", cstart, 0);
        chk("rst_z", cz, 0);
        chk("rst_valid", rvalid, 0);
        chk("rst_err", rerr, 0);
        chk("rst_cos", rcos, 0);
        do_reset();

        // T1: single A job, done on 4th WAIT cycle
        va = 1; aa = 8'h20;
        wait_start(z);
        va = 0; aa = 8'hEE;     // post-handshake change must be ignored
        chk("t1_z", z, 8'h20);
        tick();
        chk("t1_start_once", cstart, 0);
        tick(); tick(); tick();
        cdone = 1; cx = 8'h40; cy = 8'h30;
        tick();
        cdone = 0;
        chk("t1_valid", rvalid, 1);
        chk("t1_id", rid, 0);
        chk("t1_cos", rcos, 8'h40);
        chk("t1_sin", rsin, 8'h30);
        chk("t1_err", rerr, 0);
        chk("t1_z_held", cz, 8'h20);
        tick();

        // T2: both valid continuously -> A, B, A, B
        do_reset();
        va = 1; vb = 1; aa = 8'h10; ab = 8'h50;
        for (int j = 0; j < 4; j++) begin
            wait_start(z);
            zs[j] = z;
            tick();
            cdone = 1; cx = 8'(j); cy = 8'(j + 8'h80);
            tick();
            cdone = 0;
            ids[j] = rid;
            chk("t2_valid", rvalid, 1);
        end
        va = 0; vb = 0;
        chk("t2_id0", ids[0], 0);
        chk("t2_id1", ids[1], 1);
        chk("t2_id2", ids[2], 0);
        chk("t2_id3", ids[3], 1);
        chk("t2_z0", zs[0], 8'h10);
        chk("t2_z1", zs[1], 8'h50);
        chk("t2_z2", zs[2], 8'h10);
        chk("t2_z3", zs[3], 8'h50);
        tick();

        // T3: timeout
        va = 1; aa = 8'h33;
        wait_start(z);
        va = 0;
        tick();                 // first WAIT cycle
        n = 0;
        while (!rvalid && n < 100) begin tick(); n++; end
        chk("t3_latency", n, 32);
        chk("t3_err", rerr, 1);
        chk("t3_cos", rcos, 0);
        chk("t3_sin", rsin, 0);
        tick();

        // T4: done on the timeout cycle
        va = 1; aa = 8'h34;
        wait_start(z);
        va = 0;
        tick();
        repeat (31) tick();
        cdone = 1; cx = 8'h5A; cy = 8'hA5;
        tick();
        cdone = 0;
        chk("t4_valid", rvalid, 1);
        chk("t4_err", rerr, 0);
        chk("t4_cos", rcos, 8'h5A);
        chk("t4_sin", rsin, 8'hA5);
        tick();

        // T5: consumer stalls 10 cycles, stray done ignored
        rready = 0;
        va = 1; aa = 8'h77;
        wait_start(z);
        chk("t5_z", z, 8'h77);
        va = 0;
        tick();
        cdone = 1; cx = 8'h11; cy = 8'h22;
        tick();
        cdone = 0;
        va = 1; vb = 1;
        for (int i = 0; i < 10; i++) begin
            chk("t5_valid", rvalid, 1);
            chk("t5_id", rid, 0);
            chk("t5_cos", rcos, 8'h11);
            chk("t5_sin", rsin, 8'h22);
            chk("t5_err", rerr, 0);
            chk("t5_ready_a", ra, 0);
            chk("t5_ready_b", rb, 0);
            if (i == 4) begin cdone = 1; cx = 8'hFF; cy = 8'hFF; end
            else cdone = 0;
            tick();
        end
        cdone = 0; va = 0; vb = 0; rready = 1;
        tick();
        chk("t5_released", rvalid, 0);
        chk("t5_idle", busy, 0);

        // T6: reset during WAIT, then A wins the first tie
        vb = 1; ab = 8'h44;
        wait_start(z);
        vb = 0;
        tick(); tick(); tick();
        va = 1; vb = 1; aa = 8'h60; ab = 8'h61;
        #2 rst_n = 0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_start", cstart, 0);
        chk("t6_z", cz, 0);
        chk("t6_valid", rvalid, 0);
        chk("t6_ready_a", ra, 0);
        chk("t6_ready_b", rb, 0);
        tick(); tick();
        rst_n = 1;
        #1;
        chk("t6_grant_a", ra, 1);
        chk("t6_grant_b", rb, 0);
        wait_start(z);
        chk("t6_z_after", z, 8'h60);
        va = 0; vb = 0;
        tick();
        cdone = 1; cx = 8'h01; cy = 8'h02;
        tick();
        cdone = 0;
        chk("t6_valid_after", rvalid, 1);
        chk("t6_id_after", rid, 0);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
